// File: rtl/esfa_pkg.sv
// rtl/esfa_pkg.sv - shared word layout, error codes and loader states; ESFA_LOADER_CHECKSUM_EN adds the CHECK state
package esfa_pkg;

    localparam int VEC_W     = 64;
    localparam int ADDR_STEP = 8;

    // Field positions inside one 64-bit ESFA vector word
    localparam int MUT_BIT     = 0;
    localparam int EXP_BIT     = 1;
    localparam int END_BIT     = 2;
    localparam int HANDLE_LSB  = 8;
    localparam int NEW_IDX_LSB = 16;
    localparam int NEW_VAL_LSB = 24;
    localparam int SEL_LSB     = 32;
    localparam int EXP_VAL_LSB = 40;
    localparam int RSV_LSB     = 48;

    typedef struct packed {
        logic [15:0] reserved;
        logic [7:0]  exp_value;
        logic [7:0]  selector;
        logic [7:0]  new_value;
        logic [7:0]  new_index;
        logic [7:0]  handle;
        logic [4:0]  pad;
        logic        end_prog;
        logic        exp_bool;
        logic        mutating;
    } vec_word_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVF  = 2'b01,
        ERR_CSUM = 2'b10,
        ERR_RSV  = 2'b11
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
`ifdef ESFA_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERR
    } state_t;

    // A word may only be stored when its reserved upper bits are all zero
    function automatic logic rsv_clear(input logic [VEC_W-1:0] w);
        return w[VEC_W-1:RSV_LSB] == '0;
    endfunction

endpackage

// File: rtl/esfa_vector_loader_if.sv
// rtl/esfa_vector_loader_if.sv - byte stream in, vector RAM write port out
interface esfa_vector_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_din;

    // master: the loader, which takes bytes and drives the RAM port
    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_din
    );

    // slave: host byte link plus vector RAM
    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_din
    );
endinterface

// File: rtl/esfa_byte_packer.sv
// rtl/esfa_byte_packer.sv - assembles 8 bytes LSB first into one vector word
module esfa_byte_packer
    import esfa_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             byte_fire_i,
    input  logic [7:0]       byte_i,
    input  logic             consume_i,
    output logic             last_byte_o,
    output logic             word_full_o,
    output logic [VEC_W-1:0] word_o
);

    logic [2:0]       cnt_q;
    logic [VEC_W-1:0] word_q;
    logic             full_q;

    // Byte slot counter, assembly register and full flag
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            cnt_q  <= 3'd0;
            word_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (byte_fire_i) begin
                word_q[{cnt_q, 3'b000} +: 8] <= byte_i;
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    full_q <= 1'b1;
                end
            end else if (consume_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign last_byte_o = (cnt_q == 3'd7);
    assign word_full_o = full_q;
    assign word_o      = word_q;

endmodule

// File: rtl/esfa_vector_loader.sv
// rtl/esfa_vector_loader.sv - loads a byte stream into vector RAM; ESFA_LOADER_CHECKSUM_EN enables the trailing XOR checksum byte
module esfa_vector_loader
    import esfa_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    esfa_vector_loader_if.master bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           error_o,
    output logic [15:0]          words_written_o
);

    localparam logic [15:0]       MAX_W16 = 16'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       ww_q;
    logic              done_q;
    err_code_t         err_q;
`ifdef ESFA_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    logic             in_ready;
    logic             fire;
    logic             idle_like;
    logic             clear;
    logic             pack_fire;
    logic             last_byte;
    logic             word_full;
    logic [VEC_W-1:0] word;
    logic             word_ok;

`ifdef ESFA_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == ST_COLLECT) || (state_q == ST_CHECK);
    assign busy_o   = (state_q == ST_COLLECT) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
`else
    assign in_ready = (state_q == ST_COLLECT);
    assign busy_o   = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
`endif

    assign fire      = bus.in_valid && in_ready;
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    assign clear     = idle_like && start_i;
    assign pack_fire = fire && (state_q == ST_COLLECT);
    assign word_ok   = rsv_clear(word);

    esfa_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .byte_fire_i (pack_fire),
        .byte_i      (bus.in_data),
        .consume_i   (state_q == ST_WRITE),
        .last_byte_o (last_byte),
        .word_full_o (word_full),
        .word_o      (word)
    );

    // Load sequencing: collect, validate/write, optional checksum, terminal states
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ww_q    <= 16'd0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
`ifdef ESFA_LOADER_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        state_q <= ST_COLLECT;
                        addr_q  <= '0;
                        ww_q    <= 16'd0;
                        done_q  <= 1'b0;
                        err_q   <= ERR_NONE;
`ifdef ESFA_LOADER_CHECKSUM_EN
                        chk_q   <= 8'd0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (fire) begin
`ifdef ESFA_LOADER_CHECKSUM_EN
                        chk_q <= chk_q ^ bus.in_data;
`endif
                        if (last_byte) begin
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!word_ok) begin
                        err_q   <= ERR_RSV;
                        state_q <= ST_ERR;
                    end else begin
                        ww_q <= ww_q + 16'd1;
                        if (word[END_BIT]) begin
`ifdef ESFA_LOADER_CHECKSUM_EN
                            state_q <= ST_CHECK;
`else
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
`endif
                        end else if (ww_q + 16'd1 == MAX_W16) begin
                            err_q   <= ERR_OVF;
                            state_q <= ST_ERR;
                        end else begin
                            addr_q  <= addr_q + STEP;
                            state_q <= ST_COLLECT;
                        end
                    end
                end
`ifdef ESFA_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (fire) begin
                        if (bus.in_data == chk_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            err_q   <= ERR_CSUM;
                            state_q <= ST_ERR;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = (state_q == ST_WRITE) && word_full && word_ok;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_din    = word;
    assign done_o         = done_q;
    assign error_o        = err_q;
    assign words_written_o = ww_q;

endmodule

// File: doc/esfa_vector_loader.md
# esfa_vector_loader

Writer side of the ESFA test-vector memory: accepts a byte stream over a valid/ready handshake, packs every 8 bytes (LSB first) into one 64-bit ESFA vector word, validates it, and writes it into the vector block RAM at byte addresses 0, 8, 16, … until a word with the end-of-program bit is stored. It sits between the host byte link and the vector memory port that the ESFA benchmark runner later reads, so programs can be loaded at run time instead of being baked into the memory image.

## Interface
- `ADDR_W`, 32: width of the `mem_addr` byte address.
- `MAX_WORDS`, 512: vector memory capacity in 64-bit words.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins a load.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `in_data` input 8: stream byte.
- `busy` output 1: load in progress.
- `done` output 1: program stored successfully (sticky).
- `error` output 2: 00 none, 01 overflow, 10 checksum, 11 reserved bits set (sticky).
- `mem_we` output 1: write strobe to vector RAM.
- `mem_addr` output ADDR_W: byte address, multiple of 8.
- `mem_din` output 64: vector word.
- `words_written` output 16: count of words written in the current load.

## Operation
- Word layout: [0] mutating, [1] expected bool, [2] end of program, [15:8] handle, [23:16] new index, [31:24] new value, [39:32] selector, [47:40] expected value, [63:48] reserved, must be 0.
- States: IDLE, COLLECT, WRITE, CHECK (only with macro), DONE, ERR.
- IDLE: `in_ready`=0. `start` → COLLECT; clears byte count, address, `words_written`, `error`, `done`, checksum.
- COLLECT: `in_ready`=1. Byte accepted when `in_valid && in_ready`; byte n (0..7) lands in bits [8n+7:8n]. The 8th accepted byte → WRITE.
- WRITE: `in_ready`=0. If reserved bits are nonzero: no write, `error`=11 → ERR. Otherwise `mem_we`=1 for exactly this cycle, `words_written` increments. Then:
  - End bit set → DONE, or CHECK when the macro is defined.
  - Else if `words_written` reaches `MAX_WORDS` → `error`=01 → ERR.
  - Else `mem_addr` += 8 → COLLECT.
- DONE/ERR: `in_ready`=0, `busy`=0. Outputs hold until `start`, which restarts the load exactly as from IDLE.
- `start` while `busy` is ignored.
- `busy`=1 in COLLECT, WRITE and CHECK.
- Reset mid-load: all state returns to reset values. RAM contents already written are left as they are.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `error`=00, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `words_written`=0; state IDLE.
- `in_ready` is decoded from registered state only, with no combinational path from `in_valid`.
- `start` at edge k → `in_ready`=1 from cycle k+1.
- 8th byte accepted at edge t → `mem_we`/`mem_addr`/`mem_din` valid in cycle t+1 → `in_ready`=1 again at t+2.
- Minimum 9 cycles per word. Gaps in `in_valid` stretch COLLECT only.
- `mem_addr` and `mem_din` stay stable while `mem_we`=1.
- `done` and `error` assert in the cycle after the deciding edge.

## Configuration
- `ESFA_LOADER_CHECKSUM_EN` defined:
  - After the end word is written, the loader enters CHECK with `in_ready`=1 and accepts one more byte.
  - That byte must equal the XOR of all program bytes; match → DONE, mismatch → `error`=10 → ERR.
- Undefined: CHECK state and the checksum register are absent, and WRITE of the end word goes directly to DONE.

## Structure
- Shared package `esfa_pkg` holds:
  - word field bit positions, `VEC_W`=64, `ADDR_STEP`=8;
  - error code constants;
  - state enum.
- Sub-module `esfa_byte_packer` holds the byte counter, the 64-bit assembly register and the `word_full` flag. The FSM and address/count logic live in `esfa_vector_loader`.

## Test plan
- Stream 24 bytes for three words (two query words, third word = 0x04 followed by seven 0x00) → three `mem_we` pulses at addr 0, 8, 16 with the exact packed `mem_din`, then `done`=1, `words_written`=3, `error`=00.
- Same stream with `in_valid` low every other cycle → identical writes. `in_ready`=0 in every WRITE cycle, and no byte is dropped or duplicated.
- `MAX_WORDS`=4, four words without the end bit → four writes at 0..24, then `error`=01, `done`=0, `in_ready`=0.
- Word with byte 7 = 0x01 → no `mem_we` for that word, `error`=11. A following `start` resets `error` to 00 and loads from addr 0.
- With `ESFA_LOADER_CHECKSUM_EN`, one end word plus checksum byte 0x04 → `done`=1. The same stream with 0x05 → `error`=10.
- Reset low for one cycle after 3 bytes of a word → all outputs at reset values. A new `start` plus 8 bytes → write at addr 0.
